lcd_refresh_driver: RTL and testbench

- Downstream consumer of the 32-byte LCD message buffer.
- Initialises an HD44780-compatible 16x2 LCD over the 8-bit parallel bus, then continuously refreshes it.
- Each refresh walks read addresses 0..31 into the buffer and writes every returned byte to the display.
- Buffer bytes 0x00-0x09 (raw decimal digits) are converted to ASCII '0'-'9' before writing.

---
 rtl/lcd_pkg.sv | 41 ++++
 rtl/lcd_bus_cycle.sv | 109 ++++++++++
 rtl/lcd_refresh_driver.sv | 153 +++++++++++++++
 tb/tb_lcd_refresh_driver.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD refresh driver.
// Holds the HD44780 command bytes, the ASCII offset for raw digits, the
// sequencing and bus-phase state types, and two small helper functions
// used by the top level: the init command ROM and the digit-to-ASCII mapping.
package lcd_pkg;

  localparam logic [7:0] CMD_FUNC_8B2L = 8'h38;
  localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
  localparam logic [7:0] CMD_CLEAR     = 8'h01;
  localparam logic [7:0] CMD_ENTRY_INC = 8'h06;
  localparam logic [7:0] CMD_LINE0     = 8'h80;
  localparam logic [7:0] CMD_LINE1     = 8'hC0;
  localparam logic [7:0] ASCII_ZERO    = 8'h30;

  typedef enum logic [1:0] {PWRUP, INIT, LINE_CMD, CHAR} lcd_state_t;

  typedef enum logic [2:0] {
    BUS_IDLE,
    BUS_SETUP,
    BUS_EN,
    BUS_HOLD,
    BUS_WAIT
  } bus_phase_t;

  // Init sequence: 8-bit bus / 2 lines, display on, clear, entry increment.
  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return CMD_FUNC_8B2L;
      2'd1:    return CMD_DISP_ON;
      2'd2:    return CMD_CLEAR;
      default: return CMD_ENTRY_INC;
    endcase
  endfunction

  // The buffer stores raw decimal digits as 0x00-0x09; everything else is
  // already a printable character.
  function automatic logic [7:0] to_lcd_char(input logic [7:0] b);
    return (b < 8'h0A) ? (b + ASCII_ZERO) : b;
  endfunction

endpackage

// File: rtl/lcd_bus_cycle.sv
// One HD44780 write transaction on the 8-bit parallel bus.
// A one-cycle start registers data/rs, then the block runs
// SETUP_CYC (en=0), EN_CYC (en=1), HOLD_CYC (en=0) and a post-write wait
// (CLEAR_CYC after the clear command, WAIT_CYC otherwise). done pulses on
// the last wait cycle; a new start is accepted from the following cycle.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           launch a write (ignored unless idle)
//   rs, data        register select and byte to write
//   lcd_data/lcd_rs registered bus values, change only on start
//   lcd_en          enable strobe
//   done            last cycle of the post-write wait
module lcd_bus_cycle
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC = 4,
  parameter int EN_CYC    = 16,
  parameter int HOLD_CYC  = 4,
  parameter int WAIT_CYC  = 2_500,
  parameter int CLEAR_CYC = 100_000,
  parameter int CNT_W     = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rs,
  input  logic [7:0] data,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_en,
  output logic       done
);

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] EN_LAST    = CNT_W'(EN_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_CYC - 1);

  bus_phase_t       phase, phase_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             is_clear;
  logic [CNT_W-1:0] wait_last;

  // The clear command needs the long wait; decided once at start.
  assign wait_last = is_clear ? CLEAR_LAST : WAIT_LAST;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= BUS_IDLE;
      cnt   <= '0;
    end else begin
      phase <= phase_next;
      cnt   <= cnt_next;
    end
  end

  // Each phase counts from zero to its last cycle, then hands over.
  always_comb begin
    phase_next = phase;
    cnt_next   = cnt + 1'b1;
    case (phase)
      BUS_IDLE: begin
        cnt_next = '0;
        if (start) phase_next = BUS_SETUP;
      end
      BUS_SETUP: if (cnt == SETUP_LAST) begin
        phase_next = BUS_EN;
        cnt_next   = '0;
      end
      BUS_EN: if (cnt == EN_LAST) begin
        phase_next = BUS_HOLD;
        cnt_next   = '0;
      end
      BUS_HOLD: if (cnt == HOLD_LAST) begin
        phase_next = BUS_WAIT;
        cnt_next   = '0;
      end
      BUS_WAIT: if (cnt == wait_last) begin
        phase_next = BUS_IDLE;
        cnt_next   = '0;
      end
      default: begin
        phase_next = BUS_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    lcd_en = (phase == BUS_EN);
    done   = (phase == BUS_WAIT) && (cnt == wait_last);
  end

  // Bus data is captured only on an accepted start so that later changes
  // of the source byte cannot disturb a write in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      lcd_data <= 8'h00;
      lcd_rs   <= 1'b0;
      is_clear <= 1'b0;
    end else if (phase == BUS_IDLE && start) begin
      lcd_data <= data;
      lcd_rs   <= rs;
      is_clear <= !rs && (data == CMD_CLEAR);
    end
  end

endmodule

// File: rtl/lcd_refresh_driver.sv
// Initialises a 16x2 HD44780 LCD, then refreshes it forever from a 32-byte
// message buffer (addresses 0-15 on line 0, 16-31 on line 1). Raw digit
// bytes 0x00-0x09 are written as ASCII '0'-'9'.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   raddr        buffer read address {line, col}
//   din          buffer byte, combinational on raddr
//   lcd_data     DB7..DB0
//   lcd_rs       0 = command, 1 = data
//   lcd_rw       tied 0 (write only)
//   lcd_en       enable strobe
//   lcd_on       LCD power, tied 1
//   init_done    sticky once the init sequence has completed
//   frame_done   one-cycle pulse after the 32nd character's wait
module lcd_refresh_driver
  import lcd_pkg::*;
#(
  parameter int PWRUP_CYC = 1_000_000,
  parameter int SETUP_CYC = 4,
  parameter int EN_CYC    = 16,
  parameter int HOLD_CYC  = 4,
  parameter int WAIT_CYC  = 2_500,
  parameter int CLEAR_CYC = 100_000
) (
  input  logic       clk,
  input  logic       rst,
  output logic [4:0] raddr,
  input  logic [7:0] din,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic       lcd_on,
  output logic       init_done,
  output logic       frame_done
);

  // All count parameters must be >= 1.
  localparam int CNT_MAX = (PWRUP_CYC > CLEAR_CYC) ? PWRUP_CYC : CLEAR_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(PWRUP_CYC - 1);

  lcd_state_t       state, state_next;
  logic [CNT_W-1:0] pwr_cnt;
  logic [1:0]       init_idx;
  logic             line;
  logic [3:0]       col;
  logic             busy;
  logic             gap;
  logic             start;
  logic             wr_rs;
  logic [7:0]       wr_data;
  logic             bus_done;

  assign raddr  = {line, col};
  assign lcd_rw = 1'b0;
  assign lcd_on = 1'b1;

  lcd_bus_cycle #(
    .SETUP_CYC(SETUP_CYC),
    .EN_CYC   (EN_CYC),
    .HOLD_CYC (HOLD_CYC),
    .WAIT_CYC (WAIT_CYC),
    .CLEAR_CYC(CLEAR_CYC),
    .CNT_W    (CNT_W)
  ) u_bus (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .rs      (wr_rs),
    .data    (wr_data),
    .lcd_data(lcd_data),
    .lcd_rs  (lcd_rs),
    .lcd_en  (lcd_en),
    .done    (bus_done)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= PWRUP;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      PWRUP:    if (pwr_cnt == PWR_LAST) state_next = INIT;
      INIT:     if (bus_done && init_idx == 2'd3) state_next = LINE_CMD;
      LINE_CMD: if (bus_done) state_next = CHAR;
      CHAR:     if (bus_done && col == 4'd15) state_next = LINE_CMD;
      default:  state_next = PWRUP;
    endcase
  end

  // One idle cycle (gap) follows every done, so a new raddr is stable for
  // a full cycle before the character write samples din.
  always_comb begin
    start   = (state != PWRUP) && !busy && !gap;
    wr_data = 8'h00;
    wr_rs   = 1'b0;
    case (state)
      INIT:     wr_data = init_cmd(init_idx);
      LINE_CMD: wr_data = line ? CMD_LINE1 : CMD_LINE0;
      CHAR: begin
        wr_data = to_lcd_char(din);
        wr_rs   = 1'b1;
      end
      default: ;
    endcase
  end

  // col wraps 15 -> 0 at end of line, which also toggles line; raddr
  // therefore wraps 31 -> 0 at the end of each frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwr_cnt    <= '0;
      init_idx   <= 2'd0;
      line       <= 1'b0;
      col        <= 4'd0;
      busy       <= 1'b0;
      gap        <= 1'b0;
      init_done  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      gap        <= bus_done;
      frame_done <= 1'b0;
      if (start)         busy <= 1'b1;
      else if (bus_done) busy <= 1'b0;
      if (state == PWRUP) pwr_cnt <= pwr_cnt + 1'b1;
      if (bus_done) begin
        case (state)
          INIT: begin
            if (init_idx == 2'd3) begin
              init_done <= 1'b1;
              line      <= 1'b0;
              col       <= 4'd0;
            end else begin
              init_idx <= init_idx + 2'd1;
            end
          end
          CHAR: begin
            col <= col + 4'd1;
            if (col == 4'd15) begin
              line       <= ~line;
              frame_done <= line;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lcd_refresh_driver.sv
// Self-checking bench for lcd_refresh_driver with small timing parameters.
// A buffer model answers raddr combinationally; expected LCD traffic is
// derived from the write order (init commands, line command, 16 characters
// per line) and the digit-to-ASCII rule.
module tb_lcd_refresh_driver;

  localparam int PWRUP_CYC = 10;
  localparam int SETUP_CYC = 1;
  localparam int EN_CYC    = 2;
  localparam int HOLD_CYC  = 1;
  localparam int WAIT_CYC  = 3;
  localparam int CLEAR_CYC = 6;
  localparam int BUDGET    = 2000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] raddr;
  logic [7:0] din;
  logic [7:0] lcd_data;
  logic       lcd_rs, lcd_rw, lcd_en, lcd_on, init_done, frame_done;

  logic [7:0] mem [32];
  logic [7:0] din_xor = 8'h00;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fd_count = 0;
  int fd_cycles = 0;
  logic fd_prev = 1'b0;

  assign din = mem[raddr] ^ din_xor;

  lcd_refresh_driver #(
    .PWRUP_CYC(PWRUP_CYC), .SETUP_CYC(SETUP_CYC), .EN_CYC(EN_CYC),
    .HOLD_CYC(HOLD_CYC), .WAIT_CYC(WAIT_CYC), .CLEAR_CYC(CLEAR_CYC)
  ) dut (
    .clk(clk), .rst(rst), .raddr(raddr), .din(din), .lcd_data(lcd_data),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en), .lcd_on(lcd_on),
    .init_done(init_done), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Pulse counter for frame_done: number of pulses and total high cycles.
  always @(negedge clk) begin
    if (frame_done === 1'b1) fd_cycles++;
    if (frame_done === 1'b1 && fd_prev !== 1'b1) fd_count++;
    fd_prev = frame_done;
  end

  function automatic logic [7:0] model_char(input logic [7:0] b);
    int v;
    v = b;
    if (v < 10) return 8'(v + 48);
    return b;
  endfunction

  // Write k (0..33) of a refresh frame: line-0 command, 16 chars,
  // line-1 command, 16 chars. addr = -1 for commands.
  task automatic model_frame_write(input int k, output logic rs,
                                   output logic [7:0] data, output int addr);
    if (k == 0) begin
      rs = 1'b0; data = 8'h80; addr = -1;
    end else if (k <= 16) begin
      addr = k - 1; rs = 1'b1; data = model_char(mem[addr]);
    end else if (k == 17) begin
      rs = 1'b0; data = 8'hC0; addr = -1;
    end else begin
      addr = k - 2; rs = 1'b1; data = model_char(mem[addr]);
    end
  endtask

  // Waits for the next enable pulse, captures bus values at its rise and
  // measures its width; returns at the first low sample after it.
  task automatic get_write(output logic rs, output logic [7:0] data,
                           output logic [4:0] addr, output int rise,
                           output int width, output bit timeout);
    int n = 0;
    timeout = 1'b0; rs = 1'b0; data = 8'h00; addr = 5'd0; rise = 0; width = 0;
    @(negedge clk);
    while (lcd_en !== 1'b1 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    if (lcd_en !== 1'b1) begin
      timeout = 1'b1;
      return;
    end
    rise = cyc; rs = lcd_rs; data = lcd_data; addr = raddr;
    while (lcd_en === 1'b1 && width < BUDGET) begin
      width++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (lcd_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_en got %b want 0", lcd_en); end
    checks++; if (raddr !== 5'd0) begin errors++; $display("[TB] FAIL reset_raddr got %h want 00", raddr); end
    checks++; if (lcd_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_data got %h want 00", lcd_data); end
    checks++; if (lcd_rs !== 1'b0 || lcd_rw !== 1'b0) begin errors++; $display("[TB] FAIL reset_rs_rw got %b%b want 00", lcd_rs, lcd_rw); end
    checks++; if (lcd_on !== 1'b1) begin errors++; $display("[TB] FAIL reset_on got %b want 1", lcd_on); end
    checks++; if (init_done !== 1'b0 || frame_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags got %b%b want 00", init_done, frame_done); end
    rst = 1'b0;
  endtask

  task automatic test_init();
    logic rs;
    logic [7:0] d;
    logic [4:0] a;
    int rise [4];
    int w;
    bit to;
    int low = 0;
    int n = 0;
    logic [7:0] exp_cmd [4];
    exp_cmd = '{8'h38, 8'h0C, 8'h01, 8'h06};
    for (int i = 0; i < PWRUP_CYC; i++) begin
      @(negedge clk);
      if (lcd_en === 1'b0) low++;
    end
    checks++; if (low != PWRUP_CYC) begin errors++; $display("[TB] FAIL pwrup_quiet got %0d low cycles want %0d", low, PWRUP_CYC); end
    for (int i = 0; i < 4; i++) begin
      get_write(rs, d, a, rise[i], w, to);
      checks++; if (to) begin errors++; $display("[TB] FAIL init_timeout[%0d] got no en pulse want pulse", i); end
      checks++; if (rs !== 1'b0 || d !== exp_cmd[i]) begin errors++; $display("[TB] FAIL init_cmd[%0d] got rs=%b data=%h want rs=0 data=%h", i, rs, d, exp_cmd[i]); end
      checks++; if (w != EN_CYC) begin errors++; $display("[TB] FAIL init_en_width[%0d] got %0d want %0d", i, w, EN_CYC); end
      if (i == 3) begin
        checks++; if (init_done !== 1'b0) begin errors++; $display("[TB] FAIL init_done_early got %b want 0", init_done); end
      end
    end
    checks++; if (rise[1] - rise[0] != rise[2] - rise[1]) begin errors++; $display("[TB] FAIL init_gap_equal got %0d want %0d", rise[2] - rise[1], rise[1] - rise[0]); end
    checks++; if ((rise[3] - rise[2]) - (rise[2] - rise[1]) != CLEAR_CYC - WAIT_CYC) begin
      errors++; $display("[TB] FAIL clear_gap got extra %0d want %0d", (rise[3] - rise[2]) - (rise[2] - rise[1]), CLEAR_CYC - WAIT_CYC);
    end
    while (init_done !== 1'b1 && lcd_en !== 1'b1 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    checks++; if (init_done !== 1'b1) begin errors++; $display("[TB] FAIL init_done_rise got %b want 1", init_done); end
    checks++; if (n != HOLD_CYC + WAIT_CYC) begin errors++; $display("[TB] FAIL init_done_time got %0d want %0d", n, HOLD_CYC + WAIT_CYC); end
  endtask

  task automatic test_line0_text();
    logic rs, ers;
    logic [7:0] d, ed;
    logic [4:0] a;
    int r, w, ea;
    bit to;
    for (int k = 0; k <= 16; k++) begin
      get_write(rs, d, a, r, w, to);
      model_frame_write(k, ers, ed, ea);
      checks++; if (to) begin errors++; $display("[TB] FAIL line0_timeout[%0d] got no pulse want pulse", k); end
      checks++; if (rs !== ers || d !== ed) begin errors++; $display("[TB] FAIL line0_write[%0d] got rs=%b data=%h want rs=%b data=%h", k, rs, d, ers, ed); end
      if (ea >= 0) begin
        checks++; if (a !== 5'(ea)) begin errors++; $display("[TB] FAIL line0_raddr[%0d] got %0d want %0d", k, a, ea); end
      end
    end
  endtask

  task automatic test_digit_conversion();
    logic rs, ers;
    logic [7:0] d, ed, fixed;
    logic [4:0] a;
    int r, w, ea;
    bit to;
    for (int k = 17; k <= 33; k++) begin
      get_write(rs, d, a, r, w, to);
      model_frame_write(k, ers, ed, ea);
      checks++; if (to) begin errors++; $display("[TB] FAIL line1_timeout[%0d] got no pulse want pulse", k); end
      checks++; if (rs !== ers || d !== ed) begin errors++; $display("[TB] FAIL line1_write[%0d] got rs=%b data=%h want rs=%b data=%h", k, rs, d, ers, ed); end
      fixed = 8'hFF;
      case (ea)
        16: fixed = 8'h34;
        17: fixed = 8'h0A;
        18: fixed = 8'h4D;
        22: fixed = 8'h33;
        23: fixed = 8'h37;
        default: fixed = 8'hFF;
      endcase
      if (fixed != 8'hFF) begin
        checks++; if (d !== fixed) begin errors++; $display("[TB] FAIL digit_conv[%0d] got %h want %h", ea, d, fixed); end
      end
    end
  endtask

  task automatic test_frames();
    logic rs, ers;
    logic [7:0] d, ed;
    logic [4:0] a;
    int r, w, ea, base_c, base_w;
    bit to;
    get_write(rs, d, a, r, w, to);
    checks++; if (to || rs !== 1'b0 || d !== 8'h80) begin errors++; $display("[TB] FAIL frame_start got rs=%b data=%h want rs=0 data=80", rs, d); end
    checks++; if (fd_count != 1) begin errors++; $display("[TB] FAIL frame1_done got %0d pulses want 1", fd_count); end
    base_c = fd_count;
    base_w = fd_cycles;
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < 34; k++) begin
        if (k == 0 && f == 0) continue;
        if (k == 1) begin
          for (int i = 0; i < 32; i++)
            mem[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 9)) : 8'($urandom_range(0, 255));
        end
        get_write(rs, d, a, r, w, to);
        model_frame_write(k, ers, ed, ea);
        checks++; if (to || rs !== ers || d !== ed) begin errors++; $display("[TB] FAIL frame_write[%0d.%0d] got rs=%b data=%h want rs=%b data=%h", f, k, rs, d, ers, ed); end
        checks++; if (w != EN_CYC) begin errors++; $display("[TB] FAIL frame_en_width[%0d.%0d] got %0d want %0d", f, k, w, EN_CYC); end
        if (ea >= 0) begin
          checks++; if (a !== 5'(ea)) begin errors++; $display("[TB] FAIL frame_raddr[%0d.%0d] got %0d want %0d", f, k, a, ea); end
        end
        if (k == 0) begin
          checks++; if (fd_count - base_c != f) begin errors++; $display("[TB] FAIL frame_done_count[%0d] got %0d want %0d", f, fd_count - base_c, f); end
        end
      end
    end
    get_write(rs, d, a, r, w, to);
    checks++; if (to || rs !== 1'b0 || d !== 8'h80) begin errors++; $display("[TB] FAIL frame_wrap got rs=%b data=%h want rs=0 data=80", rs, d); end
    checks++; if (fd_count - base_c != 2) begin errors++; $display("[TB] FAIL frame_done_pulses got %0d want 2", fd_count - base_c); end
    checks++; if (fd_cycles - base_w != 2) begin errors++; $display("[TB] FAIL frame_done_width got %0d cycles want 2", fd_cycles - base_w); end
  endtask

  task automatic test_din_stability();
    logic [7:0] held, exp;
    bit stable;
    int n;
    for (int j = 0; j < 3; j++) begin
      n = 0;
      @(negedge clk);
      while (lcd_en !== 1'b1 && n < BUDGET) begin
        @(negedge clk);
        n++;
      end
      checks++; if (lcd_en !== 1'b1) begin errors++; $display("[TB] FAIL din_timeout[%0d] got no pulse want pulse", j); end
      exp = model_char(mem[j]);
      checks++; if (lcd_rs !== 1'b1 || lcd_data !== exp || raddr !== 5'(j)) begin
        errors++; $display("[TB] FAIL din_char[%0d] got rs=%b data=%h addr=%0d want rs=1 data=%h addr=%0d", j, lcd_rs, lcd_data, raddr, exp, j);
      end
      held = lcd_data;
      stable = 1'b1;
      n = 0;
      while (lcd_en === 1'b1 && n < BUDGET) begin
        din_xor = 8'($urandom_range(1, 255));
        @(negedge clk);
        n++;
        if (lcd_data !== held || lcd_rs !== 1'b1) stable = 1'b0;
      end
      repeat (HOLD_CYC - 1) begin
        @(negedge clk);
        if (lcd_data !== held || lcd_rs !== 1'b1) stable = 1'b0;
      end
      din_xor = 8'h00;
      checks++; if (!stable) begin errors++; $display("[TB] FAIL din_stability[%0d] got data=%h want %h held", j, lcd_data, held); end
    end
  endtask

  task automatic test_mid_reset();
    logic rs, ers;
    logic [7:0] d, ed;
    logic [4:0] a;
    int r, w, ea, n;
    bit to;
    for (int k = 4; k <= 21; k++) begin
      get_write(rs, d, a, r, w, to);
      model_frame_write(k, ers, ed, ea);
      checks++; if (to || rs !== ers || d !== ed) begin errors++; $display("[TB] FAIL pre_reset_write[%0d] got rs=%b data=%h want rs=%b data=%h", k, rs, d, ers, ed); end
    end
    n = 0;
    @(negedge clk);
    while (lcd_en !== 1'b1 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    checks++; if (lcd_en !== 1'b1 || raddr !== 5'd20) begin errors++; $display("[TB] FAIL pre_reset_addr got en=%b raddr=%0d want en=1 raddr=20", lcd_en, raddr); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (lcd_en !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_en got %b want 0", lcd_en); end
    checks++; if (raddr !== 5'd0) begin errors++; $display("[TB] FAIL mid_reset_raddr got %0d want 0", raddr); end
    checks++; if (init_done !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_init_done got %b want 0", init_done); end
    checks++; if (lcd_data !== 8'h00) begin errors++; $display("[TB] FAIL mid_reset_data got %h want 00", lcd_data); end
    test_init();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'($urandom_range(0, 255));
    mem[0] = 8'h54; mem[1] = 8'h49; mem[2] = 8'h4D; mem[3] = 8'h45; mem[4] = 8'h3A;
    for (int i = 5; i < 16; i++) mem[i] = 8'h20;
    mem[16] = 8'h04; mem[17] = 8'h0A; mem[18] = 8'h4D; mem[22] = 8'h03; mem[23] = 8'h07;
    $display("[TB] starting lcd_refresh_driver bench");
    test_reset();
    test_init();
    test_line0_text();
    test_digit_conversion();
    test_frames();
    test_din_stability();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
